frog_sprite_core: RTL and testbench

//  Pixel-pipeline stage consuming the 32x32, 2-bit-index frog sprite RAM read port.
//  - Maps the current scan coordinate (x,y) to a sprite RAM read address.
//  - Takes the 2-bit colour index returned one cycle later and resolves it through a 4-entry 12-bit palette.
//  - Overlays the result on the upstream RGB stream; index KEY_IDX is transparent.
//  - Also forwards bus writes to the sprite RAM write port and owns the control/palette registers.

---
 rtl/frog_sprite_pkg.sv | 18 +
 rtl/frog_palette_rf.sv | 30 +++
 rtl/frog_sprite_core.sv | 117 +++++++++++
 tb/tb_frog_sprite_core.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frog_sprite_pkg.sv
// Shared constants and types for the frog sprite overlay stage.
package frog_sprite_pkg;

    typedef logic [11:0] rgb_t;
    typedef logic [1:0]  cidx_t;

    localparam logic [2:0] REG_X0       = 3'd0;
    localparam logic [2:0] REG_Y0       = 3'd1;
    localparam logic [2:0] REG_CTRL     = 3'd2;
    localparam logic [2:0] REG_PAL_BASE = 3'd4;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_HFLIP = 1;

    // Entry 0 sits in the low bits: {pal3, pal2, pal1, pal0}.
    localparam logic [47:0] PAL_DEFAULT = {12'hFF0, 12'h080, 12'h0F0, 12'h000};

endpackage

// File: rtl/frog_palette_rf.sv
// Small palette register file: one synchronous write port, one combinational read port.
module frog_palette_rf #(
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned DATA_W = 12,
    parameter logic [(2**IDX_W)*DATA_W-1:0] RST_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata_c
);

    localparam int unsigned N = 2**IDX_W;

    logic [N-1:0][DATA_W-1:0] r_mem;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_mem <= RST_VAL;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/frog_sprite_core.sv
// Frog sprite overlay: scan coordinate -> sprite RAM address -> palette -> composite
// onto the upstream RGB stream, plus bus decode for sprite RAM and control registers.
module frog_sprite_core
    import frog_sprite_pkg::*;
#(
    parameter int unsigned CD      = 2,
    parameter int unsigned W_BITS  = 5,
    parameter int unsigned H_BITS  = 5,
    parameter int unsigned COORD_W = 11,
    parameter int unsigned RGB_W   = 12,
    parameter int unsigned KEY_IDX = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cs,
    input  logic                     write,
    input  logic [13:0]              addr,
    input  logic [31:0]              wr_data,
    input  logic [COORD_W-1:0]       x,
    input  logic [COORD_W-1:0]       y,
    input  logic [RGB_W-1:0]         si_rgb,
    output logic [RGB_W-1:0]         so_rgb,
    output logic                     ram_we,
    output logic [W_BITS+H_BITS-1:0] ram_addr_w,
    output logic [CD-1:0]            ram_din,
    output logic [W_BITS+H_BITS-1:0] ram_addr_r,
    input  logic [CD-1:0]            ram_dout
);

    localparam int unsigned AW = W_BITS + H_BITS;

    logic [COORD_W-1:0] r_x0;
    logic [COORD_W-1:0] r_y0;
    logic [1:0]         r_ctrl;

    logic               w_reg_wr;
    logic               w_pal_we;
    logic [RGB_W-1:0]   w_pal_rgb;
    logic               w_unused_bits;

    logic [COORD_W-1:0] w_xr;
    logic [COORD_W-1:0] w_yr;
    logic               w_hit;
    logic [W_BITS-1:0]  w_col;

    logic               r_hit1;
    logic [RGB_W-1:0]   r_rgb1;
    logic               r_hit2;
    logic [RGB_W-1:0]   r_rgb2;

    // Sprite RAM writes pass straight through for a single cycle.
    assign ram_we     = cs & write & ~addr[13];
    assign ram_addr_w = addr[AW-1:0];
    assign ram_din    = wr_data[CD-1:0];

    assign w_reg_wr      = cs & write & addr[13];
    assign w_pal_we      = w_reg_wr & addr[2];
    assign w_unused_bits = ^{addr[12:AW], wr_data[31:RGB_W]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_x0   <= '0;
            r_y0   <= '0;
            r_ctrl <= '0;
        end else if (w_reg_wr) begin
            case (addr[2:0])
                REG_X0:   r_x0   <= wr_data[COORD_W-1:0];
                REG_Y0:   r_y0   <= wr_data[COORD_W-1:0];
                REG_CTRL: r_ctrl <= wr_data[1:0];
                default: ;
            endcase
        end
    end

    frog_palette_rf #(
        .IDX_W   (CD),
        .DATA_W  (RGB_W),
        .RST_VAL (PAL_DEFAULT)
    ) u_palette (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_we      (w_pal_we),
        .i_waddr   (addr[CD-1:0]),
        .i_wdata   (wr_data[RGB_W-1:0]),
        .i_raddr   (ram_dout),
        .o_rdata_c (w_pal_rgb)
    );

    // Negative offsets wrap to large unsigned values, so they fall outside the sprite.
    assign w_xr  = x - r_x0;
    assign w_yr  = y - r_y0;
    assign w_hit = r_ctrl[CTRL_EN]
                 & (w_xr[COORD_W-1:W_BITS] == '0)
                 & (w_yr[COORD_W-1:H_BITS] == '0);
    assign w_col = r_ctrl[CTRL_HFLIP] ? ~w_xr[W_BITS-1:0] : w_xr[W_BITS-1:0];

    // The RAM's own output register acts as the index stage, so hit/rgb only
    // need one more register to line up with ram_dout.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_addr_r <= '0;
            r_hit1     <= 1'b0;
            r_rgb1     <= '0;
            r_hit2     <= 1'b0;
            r_rgb2     <= '0;
            so_rgb     <= '0;
        end else begin
            ram_addr_r <= {w_yr[H_BITS-1:0], w_col};
            r_hit1     <= w_hit;
            r_rgb1     <= si_rgb;
            r_hit2     <= r_hit1;
            r_rgb2     <= r_rgb1;
            so_rgb     <= (r_hit2 && (ram_dout != CD'(KEY_IDX))) ? w_pal_rgb : r_rgb2;
        end
    end

endmodule

// File: tb/tb_frog_sprite_core.sv
// Directed bench for frog_sprite_core with an in-flight-pixel reference model.
module tb_frog_sprite_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs;
    logic        write;
    logic [13:0] addr;
    logic [31:0] wr_data;
    logic [10:0] x;
    logic [10:0] y;
    logic [11:0] si_rgb;
    logic [11:0] so_rgb;
    logic        ram_we;
    logic [9:0]  ram_addr_w;
    logic [1:0]  ram_din;
    logic [9:0]  ram_addr_r;
    logic [1:0]  ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frog_sprite_core dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cs         (cs),
        .write      (write),
        .addr       (addr),
        .wr_data    (wr_data),
        .x          (x),
        .y          (y),
        .si_rgb     (si_rgb),
        .so_rgb     (so_rgb),
        .ram_we     (ram_we),
        .ram_addr_w (ram_addr_w),
        .ram_din    (ram_din),
        .ram_addr_r (ram_addr_r),
        .ram_dout   (ram_dout)
    );

    // Sprite RAM: registered read-first port, write port driven by the DUT.
    logic [1:0] sram [1024];
    initial for (int i = 0; i < 1024; i++) sram[i] = 2'd0;
    always @(posedge clk) begin
        ram_dout <= sram[ram_addr_r];
        if (ram_we) sram[ram_addr_w] <= ram_din;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, expv, $time);
        end
    endtask

    // Reference model: each pixel is a record that ages one step per clock;
    // its colour index is fetched at age 2 and it is resolved at age 3.
    typedef struct {
        bit hit;
        int addr;
        int rgb;
        int idx;
        int age;
    } pix_t;

    int   m_x0, m_y0;
    bit   m_en, m_hflip;
    int   m_pal [4];
    int   m_mem [1024];
    pix_t q [$];
    pix_t p, np;
    int   exp_so, exp_ra;
    int   xr, yr, col;
    bit   m_live = 1'b0;

    initial for (int i = 0; i < 1024; i++) m_mem[i] = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_x0 = 0; m_y0 = 0; m_en = 0; m_hflip = 0;
            m_pal = '{'h000, 'h0F0, 'h080, 'hFF0};
            q.delete();
            exp_so = 0;
            exp_ra = 0;
            m_live = 1'b1;
        end else begin
            for (int i = 0; i < q.size(); i++) begin
                q[i].age = q[i].age + 1;
                if (q[i].age == 2) q[i].idx = m_mem[q[i].addr];
            end
            if (q.size() > 0 && q[0].age == 3) begin
                p = q.pop_front();
                exp_so = (p.hit && p.idx != 0) ? m_pal[p.idx] : p.rgb;
            end
            xr = (int'(x) - m_x0) & 'h7FF;
            yr = (int'(y) - m_y0) & 'h7FF;
            col = m_hflip ? 31 - (xr % 32) : xr % 32;
            np.hit  = m_en && xr < 32 && yr < 32;
            np.addr = (yr % 32) * 32 + col;
            np.rgb  = int'(si_rgb);
            np.idx  = 0;
            np.age  = 1;
            q.push_back(np);
            exp_ra = np.addr;
            if (cs && write) begin
                if (!addr[13]) m_mem[int'(addr[9:0])] = int'(wr_data[1:0]);
                else if (addr[2]) m_pal[int'(addr[1:0])] = int'(wr_data[11:0]);
                else if (addr[1:0] == 2'd0) m_x0 = int'(wr_data[10:0]);
                else if (addr[1:0] == 2'd1) m_y0 = int'(wr_data[10:0]);
                else if (addr[1:0] == 2'd2) begin
                    m_en    = wr_data[0];
                    m_hflip = wr_data[1];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("so_rgb", 32'(so_rgb), 32'(exp_so));
            chk("ram_addr_r", 32'(ram_addr_r), 32'(exp_ra));
            chk("ram_we", 32'(ram_we), 32'(cs && write && !addr[13]));
            if (cs && write && !addr[13]) begin
                chk("ram_addr_w", 32'(ram_addr_w), 32'(addr[9:0]));
                chk("ram_din", 32'(ram_din), 32'(wr_data[1:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_wr(input logic [13:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        step();
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic pix(input int xx, input int yy, input int rgb);
        x = 11'(xx); y = 11'(yy); si_rgb = 12'(rgb);
    endtask

    initial begin
        reset_n = 1'b0; cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        pix(0, 0, 'h123);
        steps(3);
        chk("reset so_rgb", 32'(so_rgb), 32'h0);
        chk("reset ram_addr_r", 32'(ram_addr_r), 32'h0);

        // Disabled sprite: passthrough after exactly 3 clocks.
        reset_n = 1'b1;
        step(); chk("release so_rgb c1", 32'(so_rgb), 32'h0);
        step(); chk("release so_rgb c2", 32'(so_rgb), 32'h0);
        step(); chk("passthrough", 32'(so_rgb), 32'h123);

        // Origin (100,50), RAM[0]=1 -> default pal[1]
        bus_wr(14'h0000, 32'd1);
        bus_wr(14'h2000, 32'd100);
        bus_wr(14'h2001, 32'd50);
        bus_wr(14'h2002, 32'd1);
        pix(100, 50, 'h123);
        step();   chk("origin addr", 32'(ram_addr_r), 32'd0);
        steps(2); chk("origin colour", 32'(so_rgb), 32'h0F0);
        pix(99, 50, 'h123);  steps(3); chk("left of sprite", 32'(so_rgb), 32'h123);
        pix(132, 50, 'h123); steps(3); chk("right of sprite", 32'(so_rgb), 32'h123);

        // Transparent index, then recoloured palette entry
        bus_wr(14'd37, 32'd0);
        pix(105, 51, 'h456);
        step();   chk("row1 col5 addr", 32'(ram_addr_r), 32'd37);
        steps(2); chk("key transparent", 32'(so_rgb), 32'h456);
        bus_wr(14'd38, 32'd2);
        bus_wr(14'h2006, 32'hABC);
        pix(106, 51, 'h456); steps(3); chk("pal2 rewritten", 32'(so_rgb), 32'hABC);

        // Horizontal flip addressing
        bus_wr(14'h2000, 32'd0);
        bus_wr(14'h2001, 32'd0);
        bus_wr(14'h2002, 32'd3);
        pix(0, 0, 'h456);  step(); chk("hflip x0", 32'(ram_addr_r), 32'd31);
        pix(31, 2, 'h456); step(); chk("hflip x31 y2", 32'(ram_addr_r), 32'd64);

        // Screen edge clipping, no wrap-around, wrapped origin
        bus_wr(14'h2002, 32'd1);
        bus_wr(14'h2000, 32'd630);
        bus_wr(14'd9, 32'd3);
        pix(639, 0, 'h456); steps(3); chk("right edge hit", 32'(so_rgb), 32'hFF0);
        pix(0, 0, 'h456);   steps(3); chk("no wrap", 32'(so_rgb), 32'h456);
        bus_wr(14'h2000, 32'h7FF);
        bus_wr(14'd1, 32'd2);
        pix(0, 0, 'h456);   steps(3); chk("origin -1 col1", 32'(so_rgb), 32'hABC);

        // Ignored register, write without cs, and sprite RAM write pulse
        bus_wr(14'h2003, 32'hFFFF);
        cs = 1'b0; write = 1'b1; addr = 14'h2002; wr_data = 32'd0;
        step(); write = 1'b0;
        cs = 1'b1; write = 1'b1; addr = 14'h0005; wr_data = 32'd3;
        #1;
        chk("ram_we pulse", 32'(ram_we), 32'd1);
        chk("ram_addr_w pulse", 32'(ram_addr_w), 32'd5);
        chk("ram_din pulse", 32'(ram_din), 32'd3);
        step(); cs = 1'b0; write = 1'b0;
        #1;
        chk("ram_we low", 32'(ram_we), 32'd0);

        // Streaming sweep with mid-frame register, palette and RAM writes
        for (int a = 0; a < 128; a++) bus_wr(14'(a), 32'((a * 5 + a / 7) % 4));
        bus_wr(14'h2000, 32'd20);
        bus_wr(14'h2001, 32'd10);
        for (int i = 0; i < 320; i++) begin
            pix(i % 64 + 4, 8 + i / 64, (i * 37) & 'hFFF);
            if (i % 17 == 0) begin
                cs = 1'b1; write = 1'b1; addr = 14'(32'h2004 + i % 4); wr_data = 32'(i * 91);
            end else if (i % 23 == 0) begin
                cs = 1'b1; write = 1'b1; addr = 14'h2002; wr_data = 32'(1 + 2 * ((i / 23) % 2));
            end else if (i % 29 == 0) begin
                cs = 1'b1; write = 1'b1; addr = 14'(i % 128); wr_data = 32'(i % 4);
            end else if (i % 31 == 0) begin
                cs = 1'b0; write = 1'b1; addr = 14'h2000; wr_data = 32'd5;
            end
            step();
            cs = 1'b0; write = 1'b0;
        end

        // Mid-stream reset: pipeline flushed, registers back to defaults
        reset_n = 1'b0;
        steps(2);
        reset_n = 1'b1;
        pix(0, 0, 'h789);
        step(); chk("flush c1", 32'(so_rgb), 32'h0);
        step(); chk("flush c2", 32'(so_rgb), 32'h0);
        step(); chk("post reset passthrough", 32'(so_rgb), 32'h789);
        bus_wr(14'h0000, 32'd1);
        bus_wr(14'h2002, 32'd1);
        steps(3); chk("default palette/origin", 32'(so_rgb), 32'h0F0);

        steps(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
